// File: rtl/sha256d_arbiter.sv
// Two-requester round-robin front end for a single sha256d core.
// Optional BUSY watchdog: define SHA256D_ARB_WATCHDOG_EN (limit set by WDOG_CYCLES).
module sha256d_arbiter #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [255:0] din0,
  input  logic [255:0] din1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [255:0] dout,
  output logic         err,
  output logic         core_init,
  output logic [255:0] core_input,
  input  logic         core_ready,
  input  logic [255:0] core_hash,
  input  logic         core_hash_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [1:0]     done_q, done_d;
  logic           init_q, init_d;
  logic [255:0]   dout_q, dout_d;
  logic [255:0]   cin_q, cin_d;
  logic           seen_q, seen_d;
  logic           ptr_q, ptr_d;
  logic           sel_s;
  logic           complete_s;

`ifdef SHA256D_ARB_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0]  wdog_q, wdog_d;
  logic           err_q, err_d;
  assign err = err_q;
`else
  logic           unused_wdog_s;
  assign unused_wdog_s = ^WDOG_CYCLES;
  assign err = 1'b0;
`endif

  assign complete_s = seen_q && core_ready && core_hash_valid;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      init_q  <= 1'b0;
      dout_q  <= 256'd0;
      cin_q   <= 256'd0;
      seen_q  <= 1'b0;
      ptr_q   <= 1'b0;
`ifdef SHA256D_ARB_WATCHDOG_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      init_q  <= init_d;
      dout_q  <= dout_d;
      cin_q   <= cin_d;
      seen_q  <= seen_d;
      ptr_q   <= ptr_d;
`ifdef SHA256D_ARB_WATCHDOG_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic; ptr_q names the requester that wins a tie
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    init_d  = 1'b0;
    dout_d  = dout_q;
    cin_d   = cin_q;
    seen_d  = seen_q;
    ptr_d   = ptr_q;
    sel_s   = 1'b0;
`ifdef SHA256D_ARB_WATCHDOG_EN
    wdog_d  = wdog_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (core_ready && (req0 || req1)) begin
          if (req0 && req1) begin
            sel_s = ptr_q;
          end else begin
            sel_s = req1;
          end
          cin_d   = sel_s ? din1 : din0;
          gnt_d   = sel_s ? 2'b10 : 2'b01;
          init_d  = 1'b1;
          seen_d  = 1'b0;
`ifdef SHA256D_ARB_WATCHDOG_EN
          wdog_d  = '0;
`endif
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (!core_ready) begin
          seen_d = 1'b1;
        end else begin
          seen_d = seen_q;
        end
        if (complete_s) begin
          dout_d  = core_hash;
          done_d  = gnt_q;
          gnt_d   = 2'b00;
          ptr_d   = ~gnt_q[1];
          state_d = IDLE;
        end
`ifdef SHA256D_ARB_WATCHDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          gnt_d   = 2'b00;
          ptr_d   = ~gnt_q[1];
          state_d = IDLE;
        end else begin
          wdog_d  = wdog_q + WW'(1);
          state_d = BUSY;
        end
`else
        else begin
          state_d = BUSY;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  assign gnt0       = gnt_q[0];
  assign gnt1       = gnt_q[1];
  assign done0      = done_q[0];
  assign done1      = done_q[1];
  assign core_init  = init_q;
  assign core_input = cin_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_sha256d_arbiter.sv
// Directed bench for sha256d_arbiter with a behavioural core model and a result scoreboard.
module tb_sha256d_arbiter;

  logic         clk, reset, req0, req1, stall;
  logic [255:0] din0, din1, dout, core_input, core_hash;
  logic         gnt0, gnt1, done0, done1, err, core_init, core_ready, core_hash_valid;

  int errors = 0;
  int checks = 0;
  int init_cnt = 0;
  int both_gnt = 0;

  typedef struct {
    logic         who;
    logic [255:0] hash;
  } exp_t;
  exp_t sb[$];

  sha256d_arbiter #(.WDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .dout(dout), .err(err),
    .core_init(core_init), .core_input(core_input), .core_ready(core_ready),
    .core_hash(core_hash), .core_hash_valid(core_hash_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in digest of the core model
  function automatic logic [255:0] mh(input logic [255:0] m);
    return {m[127:0], m[255:128]} ^ {8{32'h5A3C_96E1}};
  endfunction

  logic         m_rdy, m_val;
  logic [255:0] m_hash;
  int           m_cnt;

  // Core model: drops ready on init, answers after four cycles
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rdy <= 1'b1; m_val <= 1'b0; m_hash <= 256'd0; m_cnt <= 0;
    end else if (core_init) begin
      m_rdy <= 1'b0; m_val <= 1'b0; m_hash <= mh(core_input); m_cnt <= 4;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_rdy <= 1'b1; m_val <= 1'b1;
      end
    end
  end
  assign core_ready      = m_rdy & ~stall;
  assign core_hash_valid = m_val;
  assign core_hash       = m_val ? m_hash : 256'd0;

  always @(negedge clk) begin
    if (core_init) init_cnt <= init_cnt + 1;
    if (gnt0 && gnt1) both_gnt <= both_gnt + 1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done0 || done1) && n < 100);
    if (!(done0 || done1)) begin
      check("done_timeout", 256'd0, 256'd1);
    end else if (sb.size() == 0) begin
      check("unexpected_done", {done1, done0}, 2'b00);
    end else begin
      e = sb.pop_front();
      check("done_who", {done1, done0}, e.who ? 2'b10 : 2'b01);
      check("dout", dout, e.hash);
      check("gnt_clear_on_done", {gnt1, gnt0}, 2'b00);
    end
  endtask

  int n_bad, cnt;
  logic [255:0] last;

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; stall = 1'b0;
    din0 = 256'd0; din1 = 256'd0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {gnt0, gnt1, done0, done1, err, core_init}, 6'b000000);
    check("reset_dout", dout, 256'd0);
    check("reset_core_input", core_input, 256'd0);
    reset = 1'b0;

    // single request
    din0 = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    req0 = 1'b1;
    sb.push_back('{who: 1'b0, hash: mh(din0)});
    last = mh(din0);
    @(negedge clk);
    check("grant0_latency", {gnt1, gnt0, core_init}, 3'b011);
    check("core_input_latched", core_input, din0);
    @(negedge clk);
    check("start_one_cycle", {gnt0, core_init}, 2'b10);
    wait_done();
    req0 = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {done1, done0, gnt1, gnt0}, 4'b0000);
    check("one_init_pulse", init_cnt, 1);
    repeat (3) @(negedge clk);
    check("dout_hold", dout, last);

    // simultaneous requests after reset alternate 0,1,0,1
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    din0 = {8{32'h0123_4567}}; din1 = {8{32'h89AB_CDEF}};
    req0 = 1'b1; req1 = 1'b1;
    sb.push_back('{who: 1'b0, hash: mh(din0)});
    sb.push_back('{who: 1'b1, hash: mh(din1)});
    for (int i = 0; i < 4; i++) begin
      wait_done();
      if (i == 0) begin
        din0 = {4{64'hDEAD_BEEF_0BAD_F00D}};
        sb.push_back('{who: 1'b0, hash: mh(din0)});
      end
      if (i == 1) begin
        din1 = {16{16'hC0DE}};
        sb.push_back('{who: 1'b1, hash: mh(din1)});
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("alternate_queue_empty", sb.size(), 0);

    // core not ready holds off the grant
    stall = 1'b1;
    din1 = {8{32'h1357_9BDF}};
    req1 = 1'b1;
    sb.push_back('{who: 1'b1, hash: mh(din1)});
    n_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (gnt0 || gnt1 || core_init) n_bad++;
    end
    check("no_grant_not_ready", n_bad, 0);
    stall = 1'b0;
    @(negedge clk);
    check("grant1_after_ready", {gnt1, gnt0, core_init}, 3'b101);
    wait_done();
    req1 = 1'b0;

    // requester drops mid-operation
    din1 = {8{32'hFEED_FACE}};
    req1 = 1'b1;
    sb.push_back('{who: 1'b1, hash: mh(din1)});
    repeat (3) @(negedge clk);
    req1 = 1'b0;
    wait_done();

    // serve requester 0 so the tie pointer favours requester 1
    din0 = {8{32'h2468_ACE0}};
    req0 = 1'b1;
    sb.push_back('{who: 1'b0, hash: mh(din0)});
    wait_done();
    req0 = 1'b0;

    // reset mid-operation
    din1 = {8{32'h7777_0001}};
    req1 = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_before_reset", {gnt1, gnt0}, 2'b10);
    reset = 1'b1;
    #1;
    check("async_reset_ctrl", {gnt0, gnt1, done0, done1, err, core_init}, 6'b000000);
    check("async_reset_dout", dout, 256'd0);
    check("async_reset_core_input", core_input, 256'd0);
    req1 = 1'b0;
    n_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0 || done1) n_bad++;
    end
    reset = 1'b0;
    check("no_done_after_reset", n_bad, 0);
    din0 = {8{32'hAAAA_5555}}; din1 = {8{32'h5555_AAAA}};
    req0 = 1'b1; req1 = 1'b1;
    sb.push_back('{who: 1'b0, hash: mh(din0)});
    sb.push_back('{who: 1'b1, hash: mh(din1)});
    wait_done();
    req0 = 1'b0;
    wait_done();
    req1 = 1'b0;

    // stuck core
    din0 = {8{32'h0F0F_F0F0}};
    req0 = 1'b1;
    @(negedge clk);
    stall = 1'b1;
`ifdef SHA256D_ARB_WATCHDOG_EN
    cnt = 0;
    while (!err && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("wdog_err_cycle", cnt, 17);
    check("wdog_abort_outputs", {gnt0, gnt1, done0, done1}, 4'b0000);
    req0 = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("wdog_err_one_cycle", {err, done0, gnt0}, 3'b000);
`else
    n_bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (err || done0) n_bad++;
    end
    check("no_wdog_err", n_bad, 0);
    check("no_wdog_still_busy", gnt0, 1'b1);
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("never_both_granted", both_gnt, 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256d_arbiter.md
SHA256D_ARBITER -- requirements
Module: sha256d_arbiter

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 1024, the maximum number of BUSY-state cycles before abort; it is used only when the watchdog is compiled in.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports req0 and req1, input, 1 bit each: requester hash requests, level, held until done.
REQ-005 SHALL have ports din0 and din1, input, 256 bits each: requester 256-bit messages, sampled at grant.
REQ-006 SHALL have ports gnt0 and gnt1, output, 1 bit each: requester owns the core.
REQ-007 SHALL have ports done0 and done1, output, 1 bit each: one-cycle pulses marking dout valid for that requester.
REQ-008 SHALL have port dout, output, 256 bits: last captured double-SHA256 result.
REQ-009 SHALL have port err, output, 1 bit: one-cycle watchdog abort pulse.
REQ-010 SHALL have port core_init, output, 1 bit: one-cycle start pulse to the sha256d core.
REQ-011 SHALL have port core_input, output, 256 bits: message to the core (the latched din).
REQ-012 SHALL have port core_ready, input, 1 bit: core idle.
REQ-013 SHALL have port core_hash, input, 256 bits: core digest.
REQ-014 SHALL have port core_hash_valid, input, 1 bit: core digest valid.

Function
REQ-015 SHALL implement an FSM with the states IDLE, START and BUSY.
REQ-016 In IDLE, with core_ready=1 and any req high, SHALL select one requester, latch its din into core_input, set that gnt and move to START on the same edge.
REQ-017 Selection SHALL be round-robin: when both requests are high, the requester not served last wins; the pointer points to requester 0 after reset.
REQ-018 In IDLE with core_ready=0, SHALL grant nothing and remain in IDLE.
REQ-019 START SHALL last exactly one cycle with core_init=1, then move to BUSY; core_init SHALL be 0 in all other states.
REQ-020 BUSY SHALL set an internal flag seen_busy when core_ready=0.
REQ-021 Completion SHALL be seen_busy=1 AND core_ready=1 AND core_hash_valid=1; on that edge dout SHALL capture core_hash.
REQ-022 On the completion edge, the matching done SHALL pulse for the next cycle, gnt SHALL clear, the pointer SHALL update, and the FSM SHALL return to IDLE.
REQ-023 Latency: req sampled at edge N gives gnt and core_init at N+1; done is high for one cycle immediately after the completion edge.
REQ-024 The next grant SHALL be possible on the edge following done (one IDLE cycle minimum).
REQ-025 gnt0 and gnt1 SHALL never both be 1; done SHALL only pulse for the currently granted requester.
REQ-026 If the granted req drops mid-operation, the operation SHALL complete and done SHALL still pulse; there is no abort by requester.
REQ-027 core_input SHALL remain stable from START until return to IDLE.
REQ-028 dout SHALL hold its value until the next completion.

Reset
REQ-029 Asserting reset SHALL force, asynchronously: state=IDLE, gnt0/gnt1/done0/done1/err/core_init=0, dout=0, core_input=0, seen_busy=0, pointer=requester 0, watchdog counter=0.
REQ-030 Reset mid-operation SHALL discard the operation with no done pulse; the first grant after release follows REQ-016.

Configuration
REQ-031 SHALL support macro SHA256D_ARB_WATCHDOG_EN.
REQ-032 With SHA256D_ARB_WATCHDOG_EN defined, a counter SHALL count BUSY cycles.
REQ-033 With SHA256D_ARB_WATCHDOG_EN defined, reaching WDOG_CYCLES without completion SHALL pulse err for one cycle, clear gnt with no done, advance the pointer and return to IDLE.
REQ-034 With SHA256D_ARB_WATCHDOG_EN not defined, there SHALL be no counter, err SHALL be tied to 0, and BUSY SHALL wait indefinitely.

Verification
REQ-035 Single request: req0=1, din0=e3b0c442...7852b855 with a real sha256d core -> gnt0 one cycle later, one core_init pulse, dout=aa6ac2d4...52c393d0, done0 one cycle, done1 never.
REQ-036 Simultaneous requests after reset: req0=req1=1 -> requester 0 served first, then requester 1; with both held, grants alternate 0,1,0,1.
REQ-037 Core not ready: core_ready forced 0 in IDLE with req1=1 -> no gnt and no core_init until core_ready=1.
REQ-038 Reset mid-operation: reset asserted in BUSY -> all outputs 0 immediately, no done; a new req0 is afterwards served normally with the pointer at 0.
REQ-039 Watchdog with macro defined and WDOG_CYCLES=16: stub core holds core_ready=0 -> err pulses after 16 BUSY cycles, gnt clears, no done; without macro, err stays 0.
REQ-040 Request drop: req1 deasserted in BUSY -> done1 still pulses and dout is correct.
